// File: rtl/mips_md_pkg.sv
// rtl/mips_md_pkg.sv - shared encodings and sign helpers for the HI/LO multiply/divide unit
package mips_md_pkg;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_FINISH = 2'b10
    } md_state_e;

    // Helpers work on a fixed wide container; callers zero-extend in and truncate out,
    // which is exact for two's-complement negation at any narrower width.
    localparam int MD_MAX_W     = 128;
    localparam int MD_DEFAULT_W = 32;
    localparam int MD_CNT_W     = $clog2(MD_DEFAULT_W) + 1;

    function automatic int md_cnt_width(input int dw);
        return $clog2(dw) + 1;
    endfunction

    function automatic logic [MD_MAX_W-1:0] md_cond_neg(input logic [MD_MAX_W-1:0] v,
                                                        input logic                neg);
        return neg ? ((~v) + MD_MAX_W'(1)) : v;
    endfunction

    function automatic logic [MD_MAX_W-1:0] md_to_mag(input logic [MD_MAX_W-1:0] v,
                                                      input logic                is_signed,
                                                      input logic                msb);
        return md_cond_neg(v, is_signed & msb);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative HI/LO multiply (shift-add) and divide (restoring) unit
module mult_div_unit
    import mips_md_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [1:0]            MDOperation,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic                  DivByZero
);

    localparam int W     = DATA_WIDTH;
    localparam int W2    = 2 * DATA_WIDTH;
    localparam int CNT_W = md_cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [W-1:0]      opb_q, opb_d;
    logic              is_div_q, is_div_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              bzero_q, bzero_d;
    logic [W-1:0]      hi_q, hi_d;
    logic [W-1:0]      lo_q, lo_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    logic              signed_op;
    logic [W-1:0]      a_mag, b_mag;
    logic [W:0]        mul_sum;
    logic [W2-1:0]     mul_next;
    logic [W:0]        div_shift;
    logic              div_ge;
    logic [W-1:0]      div_sub;
    logic [W2-1:0]     div_next;
    logic [W2-1:0]     prod_res;
    logic [W-1:0]      quo_res, rem_res;

    assign signed_op = MDOperation[0];
    assign a_mag = W'(md_to_mag(MD_MAX_W'(A), signed_op, A[W-1]));
    assign b_mag = W'(md_to_mag(MD_MAX_W'(B), signed_op, B[W-1]));

    // Multiply: acc holds {partial product, remaining multiplier bits}.
    assign mul_sum  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide: acc holds {remainder, dividend bits shifting into quotient}.
    // The remainder stays below the divisor, so the W-bit subtract is exact when taken.
    assign div_shift = {acc_q[W2-1:W], acc_q[W-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_sub   = div_shift[W-1:0] - opb_q;
    assign div_next  = div_ge ? {div_sub, acc_q[W-2:0], 1'b1}
                              : {div_shift[W-1:0], acc_q[W-2:0], 1'b0};

    assign prod_res = W2'(md_cond_neg(MD_MAX_W'(acc_q), neg_lo_q));
    assign quo_res  = W'(md_cond_neg(MD_MAX_W'(acc_q[W-1:0]), neg_lo_q));
    assign rem_res  = W'(md_cond_neg(MD_MAX_W'(acc_q[W2-1:W]), neg_hi_q));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        bzero_d  = bzero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d  = ST_CALC;
                    cnt_d    = '0;
                    acc_d    = {{W{1'b0}}, a_mag};
                    opb_d    = b_mag;
                    is_div_d = MDOperation[1];
                    neg_lo_d = signed_op & (A[W-1] ^ B[W-1]);
                    neg_hi_d = signed_op & A[W-1];
                    bzero_d  = MDOperation[1] & (B == '0);
                    dbz_d    = 1'b0;
                end
            end
            ST_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    // Zero divisor: remainder magnitude is |A| with A's sign, i.e. A itself.
                    lo_d  = bzero_q ? {W{1'b1}} : quo_res;
                    hi_d  = rem_res;
                    dbz_d = bzero_q;
                end else begin
                    hi_d = prod_res[W2-1:W];
                    lo_d = prod_res[W-1:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            bzero_q  <= bzero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign Busy      = (state_q != ST_IDLE);
    assign Done      = done_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - randomized scoreboard bench for mult_div_unit
module tb_mult_div_unit;

    localparam int DW  = 32;
    localparam int LAT = DW + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          Start;
    logic [1:0]    MDOperation;
    logic [DW-1:0] A, B;
    logic          Busy, Done, DivByZero;
    logic [DW-1:0] HI, LO;

    always #5 clk = ~clk;

    mult_div_unit #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .MDOperation(MDOperation),
        .A          (A),
        .B          (B),
        .Busy       (Busy),
        .Done       (Done),
        .HI         (HI),
        .LO         (LO),
        .DivByZero  (DivByZero)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          done_cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, q, r;
        logic [63:0] p;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd1: begin
                p = 64'(sa * sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = a;
                    e.dbz = 1'b1;
                end else if (op == 2'd2) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got Done=1 at cycle %0d expected no result", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("hi", HI, e.hi);
                chk("lo", LO, e.lo);
                chk("div_by_zero", DivByZero, e.dbz);
                chk("done_latency", cyc, e.done_cyc);
                chk("busy_at_done", Busy, 0);
                last_hi = e.hi;
                last_lo = e.lo;
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that sampled Start.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   waited = 0;
        while (Busy === 1'b1 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (Busy === 1'b1) begin
            total++;
            bad++;
            $display("FAIL issue_timeout: got Busy=1 expected idle within 200 cycles");
        end
        MDOperation = op;
        A           = a;
        B           = b;
        Start       = 1'b1;
        e           = model(op, a, b);
        e.done_cyc  = cyc + 1 + LAT;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        Start       = 1'b0;
        A           = $urandom;
        B           = $urandom;
        MDOperation = 2'($urandom);
        chk("busy_after_start", Busy, 1);
        chk("dbz_cleared_on_start", DivByZero, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int w;
        reset       = 1'b0;
        Start       = 1'b0;
        MDOperation = 2'd0;
        A           = '0;
        B           = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_dbz", DivByZero, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'd1, 32'hFFFF_FFFD, 32'd5);
        issue(2'd3, 32'hFFFF_FFF9, 32'd2);
        issue(2'd2, 32'd100, 32'd7);
        issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(2'd2, 32'h0000_1234, 32'd0);
        issue(2'd0, 32'd2, 32'd3);
        issue(2'd3, 32'hFFFF_FFFB, 32'd0);
        issue(2'd1, 32'h8000_0000, 32'h8000_0000);

        // Start during CALC and during FINISH must both be ignored
        issue(2'd0, 32'd2, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        A     = 32'd9;
        B     = 32'd9;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        chk("busy_mid_calc", Busy, 1);
        repeat (22) @(posedge clk);
        #1;
        chk("busy_in_finish", Busy, 1);
        A     = 32'd9;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        @(posedge clk);
        #1;
        chk("finish_start_ignored", Busy, 0);

        // Reset in the middle of a divide
        issue(2'd3, $urandom, $urandom);
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_busy", Busy, 0);
        chk("midrst_done", Done, 0);
        chk("midrst_hi", HI, 0);
        chk("midrst_lo", LO, 0);
        chk("midrst_dbz", DivByZero, 0);
        exp_q.delete();
        last_hi = '0;
        last_lo = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        issue(2'd0, 32'd4, 32'd4);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick());
        end

        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
        chk("hold_hi", HI, last_hi);
        chk("hold_lo", LO, last_lo);
        chk("idle_done_low", Done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port Start, input, 1 bit: request to begin an operation, sampled on a rising edge.
REQ-005 The module SHALL have port MDOperation, input, 2 bits: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 The module SHALL have ports A and B, input, DATA_WIDTH bits each: the rs and rt operands, the same buses that feed the ALU; for divides A is the dividend and B the divisor.
REQ-007 The module SHALL have port Busy, output, 1 bit: an operation is in progress.
REQ-008 The module SHALL have port Done, output, 1 bit: a one-cycle pulse when HI/LO are updated.
REQ-009 The module SHALL have ports HI and LO, output, DATA_WIDTH bits each: the architectural HI/LO registers, consumed by the mfhi/mflo writeback mux.
REQ-010 The module SHALL have port DivByZero, output, 1 bit: a sticky flag set by the last divide when B was 0.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and FINISH.
- IDLE: Start=1 latches A, B and MDOperation and goes to CALC.
- CALC: runs exactly DATA_WIDTH iterations, then goes to FINISH.
- FINISH: updates HI/LO, asserts Done, returns to IDLE.
REQ-012 Busy SHALL be 1 in CALC and FINISH and 0 in IDLE.
REQ-013 Start while Busy=1 SHALL be ignored; operands already latched SHALL NOT change.
REQ-014 Latency SHALL be fixed: for Start sampled at edge N, Done=1 in the cycle after edge N+DATA_WIDTH+1, and HI/LO hold the new values from that same edge.
REQ-015 Start in the FINISH cycle SHALL be ignored; a new Start is accepted in IDLE one cycle later at the earliest.
REQ-016 Multiply SHALL be iterative shift-add: one multiplier bit per cycle, with a 2*DATA_WIDTH-bit product; HI gets the upper half and LO the lower half.
REQ-017 Divide SHALL be iterative restoring division: one quotient bit per cycle; LO gets the quotient and HI the remainder.
REQ-018 Signed operations (MULT, DIV) SHALL convert operands to magnitudes at latch time and negate the results in FINISH.
- Product sign: A[msb] XOR B[msb].
- Quotient sign: A[msb] XOR B[msb]; quotient truncates toward zero.
- Remainder sign: follows the dividend.
REQ-019 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0, with no flag.
REQ-020 A divide with B=0 SHALL keep the full latency and give LO=0xFFFFFFFF, HI=A (original value), and DivByZero=1.
REQ-021 DivByZero SHALL be cleared by any subsequently accepted Start.
REQ-022 HI and LO SHALL hold their values between operations and SHALL change only in FINISH.
REQ-023 Done SHALL be registered, with no combinational path from Start to Busy or Done.

Reset
REQ-024 Asserting reset=0 at any time, including mid-CALC, SHALL immediately force IDLE, Busy=0, Done=0, HI=0, LO=0, DivByZero=0, and clear the iteration counter and partial results.
REQ-025 After reset deasserts, the first rising edge with Start=1 SHALL be accepted normally.

Structure
REQ-026 The shared package mips_md_pkg SHALL hold the MDOperation encodings, the FSM state encoding, and the iteration-count width constant, clog2(DATA_WIDTH)+1.
REQ-027 The block SHALL be a single module with no sub-modules; sign conversion and negation SHALL be functions in mips_md_pkg.

Verification
REQ-028 MULTU, A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; Done exactly 33 cycles after the Start edge.
REQ-029 MULT, A=0xFFFFFFFD (-3), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
REQ-030 DIV, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU, A=100, B=7 -> LO=14, HI=2.
REQ-031 DIVU, A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234, DivByZero=1; a following MULTU, A=2, B=3 -> DivByZero=0, LO=6, HI=0.
REQ-032 Start MULTU, A=2, B=3, then pulse Start with A=9 on cycle 10 -> LO=6 (second Start ignored).
REQ-033 reset=0 on cycle 15 of a DIV -> all outputs 0 immediately; a new MULTU, A=4, B=4 issued afterwards -> LO=16 after the full latency.
